seq_skip_adder: RTL and testbench

SEQ_SKIP_ADDER -- requirements
Module: seq_skip_adder

---
 rtl/seq_skip_adder.sv | 143 ++++++++++++++
 tb/tb_seq_skip_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_skip_adder.sv
// Sequential block-serial adder: adds BLOCK bits per cycle over NB=WIDTH/BLOCK cycles.
// Define SEQ_SKIP_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             bp
`ifdef SEQ_SKIP_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BLOCK;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  generate
    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("seq_skip_adder: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [KW-1:0]    r_k;
  logic             r_c, r_bp_acc, r_cout, r_bp, r_in_ready, r_out_valid;
  logic             r_ovf;

  logic [BLOCK-1:0] w_a_blk, w_b_blk;
  logic [BLOCK:0]   w_blk;
  logic [WIDTH-1:0] w_acc_nx;
  logic             w_p_blk, w_last, w_accept;

  assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_last   = (r_k == KW'(NB - 1));
  assign w_a_blk  = r_a[r_k*BLOCK +: BLOCK];
  assign w_b_blk  = r_b[r_k*BLOCK +: BLOCK];
  assign w_blk    = {1'b0, w_a_blk} + {1'b0, w_b_blk} + {{BLOCK{1'b0}}, r_c};
  assign w_p_blk  = &(w_a_blk ^ w_b_blk);

  always_comb begin
    w_acc_nx = r_acc;
    w_acc_nx[r_k*BLOCK +: BLOCK] = w_blk[BLOCK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake flags come from the next state so they are registered yet aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_out_valid <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_c      <= 1'b0;
      r_bp_acc <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_bp     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a      <= a;
          r_b      <= b;
          r_c      <= cin;
          r_k      <= '0;
          r_acc    <= '0;
          r_bp_acc <= 1'b1;
        end
        S_RUN: begin
          r_acc    <= w_acc_nx;
          r_c      <= w_blk[BLOCK];
          r_bp_acc <= r_bp_acc & w_p_blk;
          if (!w_last) r_k <= r_k + KW'(1);
          else begin
            r_sum  <= w_acc_nx;
            r_cout <= w_blk[BLOCK];
            r_bp   <= r_bp_acc & w_p_blk;
            // carry into the MSB recovered as a^b^sum at that bit
            r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_acc_nx[WIDTH-1] ^ w_blk[BLOCK];
          end
        end
        S_DONE: if (out_ready) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_bp   <= 1'b0;
          r_ovf  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign bp        = r_bp;
`ifdef SEQ_SKIP_ADDER_OVF_EN
  assign ovf       = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_seq_skip_adder.sv
// Randomized + directed bench for seq_skip_adder against an arithmetic reference model.
module tb_seq_skip_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, bp;
  logic [15:0] a, b, sum;
`ifdef SEQ_SKIP_ADDER_OVF_EN
  logic        ovf;
`endif
  logic        in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, bp2;
  logic [7:0]  a2, b2, sum2;
`ifdef SEQ_SKIP_ADDER_OVF_EN
  logic        ovf2;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_skip_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .bp(bp)
`ifdef SEQ_SKIP_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  seq_skip_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .bp(bp2)
`ifdef SEQ_SKIP_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 16/4 instance; optionally pokes in_valid with junk
  // operands while busy and holds the result for 'hold' cycles before taking it.
  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic c,
                    input int hold, input bit poke);
    logic [16:0] s17;
    int          sv, n;
    logic        e_ovf;
    s17   = {1'b0, x} + {1'b0, y} + {16'd0, c};
    sv    = int'($signed(x)) + int'($signed(y)) + int'(c);
    e_ovf = (sv > 32767) || (sv < -32768);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before", in_ready, 1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      if (n == 1) chk("sum_zero_busy", {15'd0, cout, sum}, 0);
      if (poke) begin in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); end
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 4);
    chk("sum", sum, {16'd0, s17[15:0]});
    chk("cout", cout, {31'd0, s17[16]});
    chk("bp", bp, {31'd0, &(x ^ y)});
`ifdef SEQ_SKIP_ADDER_OVF_EN
    chk("ovf", ovf, {31'd0, e_ovf});
`endif
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = 1'(i & 1); a = 16'($urandom); end
      @(posedge clk); #1;
      chk("hold", {out_valid, cout, bp, sum}, {13'd0, 1'b1, s17[16], &(x ^ y), s17[15:0]});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("taken", {in_ready, out_valid, cout, bp, sum}, {12'd0, 4'b1000, 16'd0});
`ifdef SEQ_SKIP_ADDER_OVF_EN
    chk("ovf_idle", ovf, 0);
`endif
    if (e_ovf && sv == 0) n_err++; // unreachable guard keeps e_ovf used in default build
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, out_valid, cout, bp, sum}, 0);
    chk("rst_state8", {in_ready2, out_valid2, cout2, bp2, sum2}, 0);
    @(negedge clk); rst_n = 1'b1;
    chk("rdy_low_after_rst", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_first_edge", in_ready, 1);

    op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'h5555, 16'hAAAA, 1'b1, 0, 1'b0);
    op(16'h5555, 16'hAAAA, 1'b0, 0, 1'b0);
    op(16'h1357, 16'h2468, 1'b0, 10, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 1, 1'b0);

    // abort in the second RUN cycle
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("abort_outputs", {in_ready, out_valid, cout, bp, sum}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    chk("abort_rdy", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_result", seen, 0);
    op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // single-block configuration
    @(negedge clk);
    a2 = 8'h80; b2 = 8'h80; cin2 = 1'b1; in_valid2 = 1'b1;
    @(posedge clk); #1; in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin @(posedge clk); #1; n++; end
    chk("nb1_latency", n, 1);
    chk("nb1_sum", sum2, 32'h01);
    chk("nb1_cout", cout2, 1);
    chk("nb1_bp", bp2, 0);
    out_ready2 = 1'b1;
    @(posedge clk); #1; out_ready2 = 1'b0;
    chk("nb1_taken", {in_ready2, out_valid2, sum2}, {22'd0, 2'b10, 8'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
